memory_bus_controller: RTL

MEMORY_BUS_CONTROLLER -- requirements
Module: memory_bus_controller

---
 rtl/memory_bus_controller_if.sv | 39 +++
 rtl/memory_bus_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_controller_if.sv
// Core request/response and memory-bus signals of the memory bus controller.
// master = requesting core plus memory side, slave = the controller itself.
interface memory_bus_controller_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_write;
    logic                  req_io;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_wdata_en;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  ext_ready;
    logic                  ext_cs, ext_we, ext_oe;
    logic                  mem_cs, mem_we, mem_oe;
    logic                  io_cs, io_we, io_oe;

    modport master (
        output req_valid, req_write, req_io, req_addr, req_wdata, bus_rdata, ext_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, stall,
        input  bus_addr, bus_wdata, bus_wdata_en,
        input  ext_cs, ext_we, ext_oe, mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe
    );

    modport slave (
        input  req_valid, req_write, req_io, req_addr, req_wdata, bus_rdata, ext_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, stall,
        output bus_addr, bus_wdata, bus_wdata_en,
        output ext_cs, ext_we, ext_oe, mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe
    );
endinterface

// File: rtl/memory_bus_controller.sv
// Decodes core loads/stores onto I/O, internal SRAM and external memory with fixed wait states.
// Hit completes WS+2 cycles after the accept cycle (miss: 1); requests accepted only in IDLE, stall otherwise.
module memory_bus_controller #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned IO_START_ADDR  = 16'h00,
    parameter int unsigned IO_STOP_ADDR   = 16'h3F,
    parameter int unsigned MEM_START_ADDR = 16'h40,
    parameter int unsigned MEM_STOP_ADDR  = 16'hBF,
    parameter int unsigned EXT_START_ADDR = 16'h100,
    parameter int unsigned EXT_STOP_ADDR  = 16'h5AF,
    parameter int unsigned IO_WS          = 0,
    parameter int unsigned MEM_WS         = 0,
    parameter int unsigned EXT_WS         = 2,
    parameter int unsigned TIMEOUT        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    memory_bus_controller_if.slave bus
);
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0] IO_LO  = (AW+1)'(IO_START_ADDR);
    localparam logic [AW:0] IO_HI  = (AW+1)'(IO_STOP_ADDR);
    localparam logic [AW:0] MEM_LO = (AW+1)'(MEM_START_ADDR);
    localparam logic [AW:0] MEM_HI = (AW+1)'(MEM_STOP_ADDR);
    localparam logic [AW:0] EXT_LO = (AW+1)'(EXT_START_ADDR);
    localparam logic [AW:0] EXT_HI = (AW+1)'(EXT_STOP_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {RG_NONE, RG_IO, RG_MEM, RG_EXT} region_t;

    state_t                state_q, state_d;
    region_t               region_q, region_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [3:0]            wait_q, wait_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    region_t               dec_region;
    logic [AW-1:0]         dec_addr;
    logic [3:0]            dec_ws;
    logic [AW:0]           req_addr_x;
    logic [AW:0]           io_addr_x;
    logic                  access_done;

    // One extra bit so window tests never wrap; a below-window address underflows past (hi-lo).
    function automatic logic in_win(input logic [AW:0] a, input logic [AW:0] lo,
                                    input logic [AW:0] hi);
        logic [AW:0] off;
        off = a - lo;
        return off <= (hi - lo);
    endfunction

    function automatic logic [AW-1:0] region_base(input region_t r);
        case (r)
            RG_IO:   return IO_LO[AW-1:0];
            RG_MEM:  return MEM_LO[AW-1:0];
            RG_EXT:  return EXT_LO[AW-1:0];
            default: return '0;
        endcase
    endfunction

    always_comb begin
        req_addr_x = {1'b0, bus.req_addr};
        io_addr_x  = IO_LO + req_addr_x;
        dec_region = RG_NONE;
        dec_addr   = bus.req_addr;
        if (bus.req_io) begin
            // I/O offsets are rebased into data space so bus_addr is formed the same way.
            dec_addr = io_addr_x[AW-1:0];
            if (io_addr_x <= IO_HI) dec_region = RG_IO;
        end else if (in_win(req_addr_x, EXT_LO, EXT_HI)) begin
            dec_region = RG_EXT;
        end else if (in_win(req_addr_x, MEM_LO, MEM_HI)) begin
            dec_region = RG_MEM;
        end else if (in_win(req_addr_x, IO_LO, IO_HI)) begin
            dec_region = RG_IO;
        end
        case (dec_region)
            RG_IO:   dec_ws = 4'(IO_WS);
            RG_MEM:  dec_ws = 4'(MEM_WS);
            RG_EXT:  dec_ws = 4'(EXT_WS);
            default: dec_ws = 4'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        write_d     = write_q;
        err_d       = err_q;
        wait_d      = wait_q;
        tmo_d       = tmo_q;
        access_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = dec_addr;
                    wdata_d  = bus.req_wdata;
                    write_d  = bus.req_write;
                    region_d = dec_region;
                    wait_d   = dec_ws;
                    tmo_d    = '0;
                    err_d    = (dec_region == RG_NONE);
                    state_d  = (dec_region == RG_NONE) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                access_done = (wait_q == '0) && ((region_q != RG_EXT) || bus.ext_ready);
                if (wait_q != '0) wait_d = wait_q - 4'd1;
                // Completion takes priority over a coincident timeout.
                if (access_done) begin
                    state_d = S_RESP;
                    if (!write_q) rdata_d = bus.bus_rdata;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            region_q <= RG_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wait_q   <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            tmo_q    <= tmo_d;
        end
    end

    // Strobes and bus_addr derive from the registered state only, so reset clears them at once.
    always_comb begin
        bus.io_cs        = 1'b0;
        bus.io_we        = 1'b0;
        bus.io_oe        = 1'b0;
        bus.mem_cs       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_oe       = 1'b0;
        bus.ext_cs       = 1'b0;
        bus.ext_we       = 1'b0;
        bus.ext_oe       = 1'b0;
        bus.bus_addr     = '0;
        bus.bus_wdata_en = 1'b0;
        if (state_q == S_ACCESS) begin
            bus.bus_addr     = addr_q - region_base(region_q);
            bus.bus_wdata_en = write_q;
            case (region_q)
                RG_IO: begin
                    bus.io_cs = 1'b1;
                    bus.io_we = write_q;
                    bus.io_oe = !write_q;
                end
                RG_MEM: begin
                    bus.mem_cs = 1'b1;
                    bus.mem_we = write_q;
                    bus.mem_oe = !write_q;
                end
                RG_EXT: begin
                    bus.ext_cs = 1'b1;
                    bus.ext_we = write_q;
                    bus.ext_oe = !write_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.stall     = (bus.req_valid && (state_q != S_IDLE)) || (state_q != S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_error = (state_q == S_RESP) && err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.bus_wdata = wdata_q;

endmodule
